// File: rtl/emu_time_monitor.sv
// emu_time_monitor: compares emulated time against a start/stop window and emits a
// decimated sample strobe, a sticky stop flag and a saturating sample count.
module emu_time_monitor #(
    parameter int time_width = 32,
    parameter int dec_width  = 16,
    parameter int cnt_width  = 32
) (
    input  logic                         emu_clk,
    input  logic                         emu_rst,
    input  logic signed [time_width-1:0] emu_time,
    input  logic signed [time_width-1:0] t_start,
    input  logic signed [time_width-1:0] t_stop,
    input  logic        [dec_width-1:0]  dec_thr,
    input  logic                         arm,
    output logic                         sample_en,
    output logic                         emu_stop,
    output logic        [cnt_width-1:0]  sample_count,
    output logic        [1:0]            state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
    state_t               state_q, state_d;
    logic                 sample_en_q, sample_en_d;
    logic                 emu_stop_q, emu_stop_d;
    logic [cnt_width-1:0] cnt_q, cnt_d, cnt_inc;
    logic [dec_width-1:0] dec_cnt_q, dec_cnt_d;
    logic [dec_width-1:0] dec_lat_q, dec_lat_d;
    logic                 ge_start, ge_stop;
    assign ge_start = emu_time >= t_start;
    assign ge_stop  = emu_time >= t_stop;
    assign cnt_inc  = &cnt_q ? cnt_q : cnt_q + cnt_width'(1);
    always_comb begin
        state_d     = state_q;
        sample_en_d = 1'b0;
        emu_stop_d  = emu_stop_q;
        cnt_d       = cnt_q;
        dec_cnt_d   = dec_cnt_q;
        dec_lat_d   = dec_lat_q;
        case (state_q)
            IDLE: if (arm) begin
                state_d = ARMED;
                cnt_d   = '0;
            end
            ARMED: if (ge_stop) begin
                state_d    = DONE;
                emu_stop_d = 1'b1;
            end else if (ge_start) begin
                state_d     = RUN;
                dec_lat_d   = dec_thr;
                dec_cnt_d   = dec_thr;
                sample_en_d = 1'b1;
                cnt_d       = cnt_inc;
            end
            RUN: if (ge_stop) begin
                state_d    = DONE;
                emu_stop_d = 1'b1;
            end else if (dec_cnt_q == '0) begin
                sample_en_d = 1'b1;
                dec_cnt_d   = dec_lat_q;
                cnt_d       = cnt_inc;
            end else begin
                dec_cnt_d = dec_cnt_q - dec_width'(1);
            end
            default: if (arm) begin
                state_d    = ARMED;
                emu_stop_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state_q     <= IDLE;
            sample_en_q <= 1'b0;
            emu_stop_q  <= 1'b0;
            cnt_q       <= '0;
            dec_cnt_q   <= '0;
            dec_lat_q   <= '0;
        end else begin
            state_q     <= state_d;
            sample_en_q <= sample_en_d;
            emu_stop_q  <= emu_stop_d;
            cnt_q       <= cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            dec_lat_q   <= dec_lat_d;
        end
    end
    assign sample_en    = sample_en_q;
    assign emu_stop     = emu_stop_q;
    assign sample_count = cnt_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_emu_time_monitor.sv
// tb_emu_time_monitor: directed spec scenarios plus randomized run against a
// cycle-level reference model; a second instance with a 2-bit counter covers saturation.
module tb_emu_time_monitor;
    logic               emu_clk = 1'b0;
    logic               emu_rst = 1'b0;
    logic signed [31:0] emu_time = '0;
    logic signed [31:0] t_start = '0;
    logic signed [31:0] t_stop = '0;
    logic        [15:0] dec_thr = '0;
    logic               arm = 1'b0;
    logic               sample_en, emu_stop, sat_en, sat_stop;
    logic        [31:0] sample_count;
    logic        [1:0]  sat_count, state_o, sat_state;
    int                 tests = 0;
    int                 fails = 0;
    int                 m_state = 0, m_age = 0, m_lat = 0;
    longint             m_count = 0;
    logic               m_en = 1'b0, m_stop = 1'b0;

    always #5 emu_clk = ~emu_clk;

    emu_time_monitor u_dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .emu_time(emu_time), .t_start(t_start),
        .t_stop(t_stop), .dec_thr(dec_thr), .arm(arm), .sample_en(sample_en),
        .emu_stop(emu_stop), .sample_count(sample_count), .state_o(state_o)
    );
    emu_time_monitor #(.cnt_width(2)) u_sat (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .emu_time(emu_time), .t_start(t_start),
        .t_stop(t_stop), .dec_thr(dec_thr), .arm(arm), .sample_en(sat_en),
        .emu_stop(sat_stop), .sample_count(sat_count), .state_o(sat_state)
    );

    // Reference: pulse when the number of cycles since RUN entry is a multiple of lat+1.
    task automatic cycle(input logic signed [31:0] t, input logic a, input logic r);
        emu_time = t;
        arm      = a;
        emu_rst  = r;
        @(posedge emu_clk);
        if (r) begin
            m_state = 0; m_en = 0; m_stop = 0; m_count = 0;
        end else begin
            m_en = 0;
            case (m_state)
                0: if (a) begin m_state = 1; m_count = 0; end
                1: if (t >= t_stop) begin
                    m_state = 3; m_stop = 1;
                end else if (t >= t_start) begin
                    m_state = 2; m_lat = int'(dec_thr); m_age = 0; m_en = 1; m_count++;
                end
                2: if (t >= t_stop) begin
                    m_state = 3; m_stop = 1;
                end else begin
                    m_age++;
                    m_en = (m_age % (m_lat + 1)) == 0;
                    if (m_en) m_count++;
                end
                default: if (a) begin m_state = 1; m_stop = 0; m_count = 0; end
            endcase
        end
        #1;
        arm     = 1'b0;
        emu_rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(0, 0, 1);
        tests++;
        if ({state_o, sample_en, emu_stop} !== 4'b0 || sample_count !== 32'd0 || sat_count !== 2'd0) begin
            fails++;
            $display("FAIL reset: state=%0d en=%0b stop=%0b cnt=%0d sat=%0d, required all 0",
                     state_o, sample_en, emu_stop, sample_count, sat_count);
        end
    endtask

    task automatic test_window_dec2();
        cycle(0, 0, 1);
        t_start = 10; t_stop = 20; dec_thr = 2;
        for (int t = 0; t <= 22; t++) begin
            logic exp_en;
            cycle(t, t == 0, 0);
            exp_en = (t == 10 || t == 13 || t == 16 || t == 19);
            tests++;
            if (sample_en !== exp_en || emu_stop !== (t >= 20)) begin
                fails++;
                $display("FAIL dec2 t=%0d: en=%0b stop=%0b, required en=%0b stop=%0b",
                         t, sample_en, emu_stop, exp_en, t >= 20);
            end
        end
        tests++;
        if (sample_count !== 32'd4 || state_o !== 2'd3) begin
            fails++;
            $display("FAIL dec2 end: cnt=%0d state=%0d, required 4 3", sample_count, state_o);
        end
    endtask

    task automatic test_dec0_saturation();
        cycle(0, 0, 1);
        t_start = 10; t_stop = 20; dec_thr = 0;
        for (int t = 0; t <= 21; t++) begin
            logic exp_en;
            cycle(t, t == 0, 0);
            exp_en = t >= 10 && t < 20;
            tests++;
            if (sample_en !== exp_en || sat_en !== exp_en) begin
                fails++;
                $display("FAIL dec0 t=%0d: en=%0b sat_en=%0b, required %0b", t, sample_en, sat_en, exp_en);
            end
        end
        tests++;
        if (sample_count !== 32'd10 || sat_count !== 2'd3) begin
            fails++;
            $display("FAIL dec0 end: cnt=%0d sat=%0d, required 10 3", sample_count, sat_count);
        end
    endtask

    task automatic test_rearm();
        t_start = 40; t_stop = 45; dec_thr = 1;
        cycle(21, 1, 0);
        tests++;
        if (emu_stop !== 1'b0 || sample_count !== 32'd0 || state_o !== 2'd1) begin
            fails++;
            $display("FAIL rearm: stop=%0b cnt=%0d state=%0d, required 0 0 1", emu_stop, sample_count, state_o);
        end
        for (int t = 22; t <= 46; t++) begin
            logic exp_en;
            cycle(t, 0, 0);
            exp_en = (t == 40 || t == 42 || t == 44);
            tests++;
            if (sample_en !== exp_en || emu_stop !== (t >= 45)) begin
                fails++;
                $display("FAIL rearm t=%0d: en=%0b stop=%0b, required en=%0b stop=%0b",
                         t, sample_en, emu_stop, exp_en, t >= 45);
            end
        end
        tests++;
        if (sample_count !== 32'd3 || state_o !== 2'd3) begin
            fails++;
            $display("FAIL rearm end: cnt=%0d state=%0d, required 3 3", sample_count, state_o);
        end
    endtask

    task automatic test_inverted_window();
        cycle(0, 0, 1);
        t_start = 30; t_stop = 20; dec_thr = 0;
        for (int t = 0; t <= 25; t++) begin
            cycle(t, t == 0, 0);
            tests++;
            if (sample_en !== 1'b0 || state_o !== (t >= 20 ? 2'd3 : 2'd1) || sample_count !== 32'd0) begin
                fails++;
                $display("FAIL inverted t=%0d: en=%0b state=%0d cnt=%0d, required 0 %0d 0",
                         t, sample_en, state_o, sample_count, t >= 20 ? 3 : 1);
            end
        end
    endtask

    task automatic test_midrun_reset();
        cycle(0, 0, 1);
        t_start = 10; t_stop = 20; dec_thr = 2;
        for (int t = 0; t <= 14; t++) cycle(t, t == 0, 0);
        tests++;
        if (state_o !== 2'd2) begin
            fails++;
            $display("FAIL midrun pre: state=%0d, required 2", state_o);
        end
        cycle(15, 0, 1);
        tests++;
        if ({state_o, sample_en, emu_stop} !== 4'b0 || sample_count !== 32'd0) begin
            fails++;
            $display("FAIL midrun reset: state=%0d en=%0b stop=%0b cnt=%0d, required all 0",
                     state_o, sample_en, emu_stop, sample_count);
        end
        for (int t = 0; t <= 12; t++) begin
            cycle(t, t == 0, 0);
            tests++;
            if (sample_en !== (t == 10) || sample_count !== (t >= 10 ? 32'd1 : 32'd0)) begin
                fails++;
                $display("FAIL midrun restart t=%0d: en=%0b cnt=%0d, required %0b %0d",
                         t, sample_en, sample_count, t == 10, t >= 10);
            end
        end
    endtask

    task automatic test_random();
        logic signed [31:0] t = 0;
        cycle(0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                t_start = $signed($urandom_range(0, 40)) - 5;
                t_stop  = $signed($urandom_range(0, 45)) - 5;
            end
            dec_thr = 16'($urandom_range(0, 3));
            t = ($urandom_range(0, 15) == 0) ? $signed($urandom_range(0, 60)) - 10 : t + 1;
            cycle(t, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
            tests++;
            if (state_o !== 2'(m_state) || sample_en !== m_en || emu_stop !== m_stop ||
                sample_count !== 32'(m_count) || sat_en !== m_en ||
                sat_count !== (m_count > 3 ? 2'd3 : 2'(m_count))) begin
                fails++;
                $display("FAIL random i=%0d t=%0d: state=%0d en=%0b stop=%0b cnt=%0d sat=%0d, required %0d %0b %0b %0d %0d",
                         i, t, state_o, sample_en, emu_stop, sample_count, sat_count,
                         m_state, m_en, m_stop, m_count, m_count > 3 ? 3 : m_count);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_window_dec2();
        test_dec0_saturation();
        test_rearm();
        test_inverted_window();
        test_midrun_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
